// File: rtl/nvdla_csb_master_if.sv
// CSB request/response channel between the command master and the NVDLA csb2nvdla port.
interface nvdla_csb_master_if #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  csb_valid;
  logic                  csb_ready;
  logic [ADDR_WIDTH-1:0] csb_addr;
  logic [DATA_WIDTH-1:0] csb_wdat;
  logic                  csb_write;
  logic                  csb_nposted;
  logic                  csb_rvalid;
  logic [DATA_WIDTH-1:0] csb_rdata;
  logic                  csb_wr_complete;

  modport master (
    output csb_valid, csb_addr, csb_wdat, csb_write, csb_nposted,
    input  csb_ready, csb_rvalid, csb_rdata, csb_wr_complete
  );

  modport slave (
    input  csb_valid, csb_addr, csb_wdat, csb_write, csb_nposted,
    output csb_ready, csb_rvalid, csb_rdata, csb_wr_complete
  );
endinterface

// File: rtl/nvdla_csb_master.sv
// Single-command CSB master: issues one register access, collects the response,
// optionally waits for the NVDLA interrupt, then pulses done_o (with timeout_o on expiry).
module nvdla_csb_master #(
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [DATA_WIDTH-1:0] cmd_wdat_i,
  input  logic                  cmd_write_i,
  input  logic                  cmd_wait_intr_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  timeout_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  nvdla_csb_master_if.master    csb,
  input  logic                  intr_i
);

  localparam bit          TimeoutEn = (TIMEOUT_CYCLES != 0);
  localparam int unsigned CntWidth  = TimeoutEn ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CntWidth-1:0] CntMax =
      CntWidth'(TimeoutEn ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [2:0] {StIdle, StReq, StWaitResp, StWaitIntr, StDone} state_e;

  state_e                state_q, state_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d, cnt_inc;
  logic                  timeout_q, timeout_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdat_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  write_q;
  logic                  wait_intr_q;

  logic accept;
  logic resp_window;
  logic resp_hit;
  logic expired;
  logic rd_done;

  assign accept      = (state_q == StIdle) && cmd_valid_i && !clear_i;
  // The REQ handshake cycle is already part of the response window.
  assign resp_window = ((state_q == StReq) && csb.csb_ready) || (state_q == StWaitResp);
  // Only the response matching the command kind counts.
  assign resp_hit    = write_q ? csb.csb_wr_complete : csb.csb_rvalid;
  assign expired     = TimeoutEn && (cnt_q == CntMax);
  assign rd_done     = resp_window && resp_hit && !write_q && !clear_i;
  assign cnt_inc     = (&cnt_q) ? cnt_q : cnt_q + CntWidth'(1);

  // State register plus counter and timeout flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state logic; clear_i overrides everything.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (cmd_valid_i) state_d = StReq;
      end
      StReq: begin
        if (csb.csb_ready) begin
          cnt_d = '0;
          if (resp_hit) state_d = wait_intr_q ? StWaitIntr : StDone;
          else          state_d = StWaitResp;
        end
      end
      StWaitResp: begin
        if (resp_hit) begin
          state_d = wait_intr_q ? StWaitIntr : StDone;
          cnt_d   = '0;
        end else if (expired) begin
          state_d   = StDone;
          timeout_d = 1'b1;
        end else if (TimeoutEn) begin
          cnt_d = cnt_inc;
        end
      end
      StWaitIntr: begin
        if (intr_i) begin
          state_d = StDone;
        end else if (expired) begin
          state_d   = StDone;
          timeout_d = 1'b1;
        end else if (TimeoutEn) begin
          cnt_d = cnt_inc;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (clear_i) begin
      state_d   = StIdle;
      cnt_d     = '0;
      timeout_d = 1'b0;
    end
  end

  // Command capture on accept; read data latched only on a successful read.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q      <= '0;
      wdat_q      <= '0;
      write_q     <= 1'b0;
      wait_intr_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      if (accept) begin
        addr_q      <= cmd_addr_i;
        wdat_q      <= cmd_wdat_i;
        write_q     <= cmd_write_i;
        wait_intr_q <= cmd_wait_intr_i;
      end
      if (rd_done) rdata_q <= csb.csb_rdata;
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    cmd_ready_o     = (state_q == StIdle);
    busy_o          = (state_q != StIdle);
    done_o          = (state_q == StDone);
    timeout_o       = timeout_q;
    rdata_o         = rdata_q;
    csb.csb_valid   = (state_q == StReq);
    csb.csb_addr    = addr_q;
    csb.csb_wdat    = wdat_q;
    csb.csb_write   = write_q;
    csb.csb_nposted = write_q;
  end

endmodule

// File: tb/tb_nvdla_csb_master.sv
// Bench for nvdla_csb_master: two instances (timeout 16 and 8) share the slave-side stimulus.
module tb_nvdla_csb_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        cmd_valid0, cmd_valid1;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_wdat;
  logic        cmd_write, cmd_wait_intr;
  logic        intr;
  logic        csb_ready, csb_rvalid, csb_wr_complete;
  logic [31:0] csb_rdata;

  logic        ready0, busy0, done0, to0;
  logic        ready1, busy1, done1, to1;
  logic [31:0] rdata0, rdata1;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_rd [2];

  always #5 clk = ~clk;

  nvdla_csb_master_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus0 ();
  nvdla_csb_master_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus1 ();

  assign bus0.csb_ready       = csb_ready;
  assign bus0.csb_rvalid      = csb_rvalid;
  assign bus0.csb_rdata       = csb_rdata;
  assign bus0.csb_wr_complete = csb_wr_complete;
  assign bus1.csb_ready       = csb_ready;
  assign bus1.csb_rvalid      = csb_rvalid;
  assign bus1.csb_rdata       = csb_rdata;
  assign bus1.csb_wr_complete = csb_wr_complete;

  nvdla_csb_master #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) u_dut16 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .cmd_valid_i(cmd_valid0),
    .cmd_ready_o(ready0), .cmd_addr_i(cmd_addr), .cmd_wdat_i(cmd_wdat),
    .cmd_write_i(cmd_write), .cmd_wait_intr_i(cmd_wait_intr), .busy_o(busy0),
    .done_o(done0), .timeout_o(to0), .rdata_o(rdata0), .csb(bus0), .intr_i(intr)
  );

  nvdla_csb_master #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) u_dut8 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .cmd_valid_i(cmd_valid1),
    .cmd_ready_o(ready1), .cmd_addr_i(cmd_addr), .cmd_wdat_i(cmd_wdat),
    .cmd_write_i(cmd_write), .cmd_wait_intr_i(cmd_wait_intr), .busy_o(busy1),
    .done_o(done1), .timeout_o(to1), .rdata_o(rdata1), .csb(bus1), .intr_i(intr)
  );

  // One transaction: delays count cycles; cycle 0 is the accept cycle.
  typedef struct {
    bit          sel;       // 0: timeout 16 instance, 1: timeout 8 instance
    bit          write;
    bit          wait_intr;
    bit          hold;      // keep cmd_valid high while busy
    logic [15:0] addr;
    logic [31:0] wdat;
    logic [31:0] rdat;
    int          rdy;       // REQ cycles before ready
    int          resp;      // cycles from handshake to response (0 = same cycle)
    int          intr;      // cycles from WAIT_INTR entry to intr rising
    int          junk;      // cycle of a wrong-kind response, -1 for none
    int          exp_done;  // cycle of the done_o pulse
    bit          exp_to;
    logic [31:0] exp_rdata;
  } vec_t;

  function automatic vec_t mk(input bit sel, input bit write, input bit wi,
                              input logic [15:0] addr, input logic [31:0] wdat,
                              input logic [31:0] rdat, input int rdy, input int resp,
                              input int intr_d, input int junk, input int exp_done,
                              input bit exp_to, input logic [31:0] exp_rdata);
    vec_t v;
    v.sel = sel; v.write = write; v.wait_intr = wi; v.hold = 1'b0;
    v.addr = addr; v.wdat = wdat; v.rdat = rdat;
    v.rdy = rdy; v.resp = resp; v.intr = intr_d; v.junk = junk;
    v.exp_done = exp_done; v.exp_to = exp_to; v.exp_rdata = exp_rdata;
    return v;
  endfunction

  // Reference model: outcome from the window rules, with t cycles per wait window.
  function automatic void predict(inout vec_t v);
    int t = v.sel ? 8 : 16;
    int h = 1 + v.rdy;
    int c;
    if (v.resp <= t) begin
      c = h + v.resp;
      if (!v.wait_intr)     begin v.exp_done = c + 1;          v.exp_to = 1'b0; end
      else if (v.intr < t)  begin v.exp_done = c + 2 + v.intr; v.exp_to = 1'b0; end
      else                  begin v.exp_done = c + 1 + t;      v.exp_to = 1'b1; end
      if (!v.write) exp_rd[v.sel] = v.rdat;
    end else begin
      v.exp_done = h + 1 + t;
      v.exp_to   = 1'b1;
    end
    v.exp_rdata = exp_rd[v.sel];
  endfunction

  function automatic logic [4:0] obs_ctl(input bit sel);
    if (sel) return {ready1, busy1, bus1.csb_valid, done1, to1};
    return {ready0, busy0, bus0.csb_valid, done0, to0};
  endfunction

  function automatic logic [49:0] obs_fields(input bit sel);
    if (sel) return {bus1.csb_addr, bus1.csb_wdat, bus1.csb_write, bus1.csb_nposted};
    return {bus0.csb_addr, bus0.csb_wdat, bus0.csb_write, bus0.csb_nposted};
  endfunction

  function automatic logic [31:0] obs_rdata(input bit sel);
    return sel ? rdata1 : rdata0;
  endfunction

  task automatic check(input string name, input int id, input int cyc,
                       input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s txn %0d cyc %0d got %h want %h", name, id, cyc, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cmd_valid0 = 1'b0; cmd_valid1 = 1'b0; clear = 1'b0; intr = 1'b0;
    csb_ready = 1'b0; csb_rvalid = 1'b0; csb_wr_complete = 1'b0;
    csb_rdata = 32'h0; cmd_addr = 16'h0; cmd_wdat = 32'h0;
    cmd_write = 1'b0; cmd_wait_intr = 1'b0;
  endtask

  task automatic run_txn(input vec_t v, input int id);
    int h  = 1 + v.rdy;
    int r  = h + v.resp;
    int i0 = r + 1 + v.intr;
    int d  = v.exp_done;
    logic [4:0] want;
    for (int k = 0; k <= d + 1; k++) begin
      step();
      cmd_valid0 = !v.sel && ((k == 0) || (v.hold && k <= d));
      cmd_valid1 = v.sel && ((k == 0) || (v.hold && k <= d));
      // Command fields are only sampled on accept; scramble them afterwards.
      cmd_addr      = (k == 0) ? v.addr : ~v.addr;
      cmd_wdat      = (k == 0) ? v.wdat : ~v.wdat;
      cmd_write     = (k == 0) ? v.write : ~v.write;
      cmd_wait_intr = (k == 0) ? v.wait_intr : ~v.wait_intr;
      csb_ready       = (k == h);
      csb_rvalid      = (!v.write && k == r) || (v.write && k == v.junk);
      csb_wr_complete = (v.write && k == r) || (!v.write && k == v.junk);
      csb_rdata       = (k == r) ? v.rdat : (32'hBAD0_0000 | 32'(k));
      intr            = v.wait_intr && k >= i0 && k <= d;
      want = {(k == 0 || k == d + 1), (k >= 1 && k <= d), (k >= 1 && k <= h),
              (k == d), (k == d && v.exp_to)};
      check("ctl", id, k, 64'(obs_ctl(v.sel)), 64'(want));
      if (k >= 1 && k <= h)
        check("fields", id, k, 64'(obs_fields(v.sel)),
              64'({v.addr, v.wdat, v.write, v.write}));
    end
    check("rdata", id, d + 1, 64'(obs_rdata(v.sel)), 64'(v.exp_rdata));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[11];
    vec_t v;
    idle_inputs();
    rst_n = 1'b0;
    exp_rd[0] = 32'h0;
    exp_rd[1] = 32'h0;
    repeat (3) step();

    // Reset values.
    check("reset_ctl0", 0, 0, 64'(obs_ctl(0)), 64'(5'b10000));
    check("reset_ctl1", 0, 0, 64'(obs_ctl(1)), 64'(5'b10000));
    check("reset_fields", 0, 0, 64'(obs_fields(0)), 64'h0);
    check("reset_rdata", 0, 0, 64'(rdata0), 64'h0);
    rst_n = 1'b1;
    step();

    // Responses while idle are ignored.
    for (int k = 0; k < 4; k++) begin
      step();
      csb_rvalid      = 1'b1;
      csb_wr_complete = k[0];
      csb_rdata       = 32'hFEED_0000 | 32'(k);
      check("idle_ctl", 0, k, 64'(obs_ctl(0)), 64'(5'b10000));
    end
    step();
    idle_inputs();
    check("idle_rdata0", 0, 0, 64'(rdata0), 64'h0);
    check("idle_rdata1", 0, 0, 64'(rdata1), 64'h0);

    // Directed vectors; expected outcomes worked out by hand.
    tbl[0]  = mk(0, 1, 0, 16'h5004, 32'hDEADBEEF, 32'h0,        2, 3,  0, -1, 7,  0, 32'h0);
    // Minimal read: done_o in the third cycle counting the accept cycle.
    tbl[1]  = mk(0, 0, 0, 16'h0010, 32'h0,        32'h12345678, 0, 0,  0, -1, 2,  0, 32'h12345678);
    // intr rises 10 cycles after wr_complete; done one cycle after it is seen.
    tbl[2]  = mk(0, 1, 1, 16'h0100, 32'hA5A50001, 32'h0,        1, 2,  9, -1, 15, 0, 32'h12345678);
    tbl[3]  = mk(1, 0, 0, 16'h0200, 32'h0,        32'h11111111, 0, 99, 0, -1, 10, 1, 32'h0);
    tbl[4]  = mk(1, 0, 0, 16'h0204, 32'h0,        32'hCAFEF00D, 0, 8,  0, -1, 10, 0, 32'hCAFEF00D);
    tbl[5]  = mk(0, 1, 0, 16'h0300, 32'h1,        32'h0,        0, 2,  0, 2,  4,  0, 32'h12345678);
    tbl[6]  = mk(1, 1, 1, 16'h0400, 32'h2,        32'h0,        0, 1,  8, -1, 11, 1, 32'hCAFEF00D);
    tbl[7]  = mk(1, 1, 1, 16'h0404, 32'h3,        32'h0,        0, 1,  7, -1, 11, 0, 32'hCAFEF00D);
    tbl[8]  = mk(0, 0, 1, 16'h0500, 32'h0,        32'h600DF00D, 3, 0,  0, -1, 6,  0, 32'h600DF00D);
    tbl[9]  = mk(1, 0, 0, 16'h0208, 32'h0,        32'h22222222, 1, 9,  0, -1, 11, 1, 32'hCAFEF00D);
    tbl[10] = mk(0, 0, 0, 16'h0600, 32'h0,        32'h76543210, 1, 1,  0, 2,  4,  0, 32'h76543210);
    for (int i = 0; i < 11; i++) begin
      run_txn(tbl[i], i);
      exp_rd[tbl[i].sel] = tbl[i].exp_rdata;
    end

    // Asynchronous reset while waiting for a read response.
    step();
    cmd_valid0 = 1'b1; cmd_write = 1'b0; cmd_wait_intr = 1'b0; cmd_addr = 16'h0700;
    step();
    cmd_valid0 = 1'b0; csb_ready = 1'b1;
    step();
    csb_ready = 1'b0;
    check("pre_rst_busy", 100, 2, 64'(busy0), 64'h1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_ctl", 100, 2, 64'(obs_ctl(0)), 64'(5'b10000));
    check("async_rst_rdata", 100, 2, 64'(rdata0), 64'h0);
    exp_rd[0] = 32'h0;
    exp_rd[1] = 32'h0;
    step();
    rst_n = 1'b1;

    // Soft clear while waiting for the interrupt.
    step();
    cmd_valid0 = 1'b1; cmd_write = 1'b1; cmd_wait_intr = 1'b1; cmd_addr = 16'h0704;
    step();
    cmd_valid0 = 1'b0; csb_ready = 1'b1; csb_wr_complete = 1'b1;
    step();
    csb_ready = 1'b0; csb_wr_complete = 1'b0;
    check("pre_clear_busy", 101, 2, 64'(obs_ctl(0)), 64'(5'b01000));
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clear_ctl", 101, 3, 64'(obs_ctl(0)), 64'(5'b10000));
    step();
    check("post_clear_ctl", 101, 4, 64'(obs_ctl(0)), 64'(5'b10000));
    idle_inputs();

    // Randomised transactions against the model.
    for (int n = 0; n < 300; n++) begin
      v.sel       = 1'($urandom_range(0, 1));
      v.write     = 1'($urandom_range(0, 1));
      v.wait_intr = 1'($urandom_range(0, 1));
      v.hold      = 1'($urandom_range(0, 1));
      v.addr      = 16'($urandom());
      v.wdat      = $urandom();
      v.rdat      = $urandom();
      v.rdy       = int'($urandom_range(0, 3));
      v.resp      = int'($urandom_range(0, 11));
      v.intr      = int'($urandom_range(0, 10));
      v.junk      = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 8));
      predict(v);
      run_txn(v, 200 + n);
    end

    step();
    idle_inputs();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
